// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS control unit for a shared PC/IR/MDR/A/B/ALUOut datapath
// with a unified memory behind a mem_ready handshake.
// Strobes are decoded from the state register. The exceptions are the FETCH
// ir_write/pc_write and the MEM_WR instr_done, which are qualified by mem_ready.
// Define CTRL_JAL_JR_EN to build jal/jr support. Without it, those encodings decode to FAULT.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 on ready
// DECODE   | read regs, precompute branch target in ALUOut
// MEM_ADDR | ALUOut <= A + signext(imm)
// MEM_RD   | load data into MDR, wait for ready
// MEM_WB   | rt <= MDR
// MEM_WR   | store B, wait for ready
// R_EXE    | ALUOut <= A funct B
// R_WB     | rd <= ALUOut
// BEQ/BNE  | compare A,B; conditional PC <= ALUOut
// JUMP     | PC <= jump target
// I_EXE    | ALUOut <= A add/and imm
// I_WB     | rt <= ALUOut
// JAL      | $31 <= PC, PC <= jump target
// JR       | PC <= A
// FAULT    | sticky error, left only by reset
module multicycle_ctrl #(
  parameter int WAIT_CNT_W = 4,
  parameter int WAIT_LIMIT = 15,
  parameter int RETIRE_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                mem_ready,
  output logic                alusrc_a,
  output logic [1:0]          alusrc_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_src,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_beq,
  output logic                pc_write_bne,
  output logic                instr_done,
  output logic                fault,
  output logic [RETIRE_W-1:0] retire_count,
  output logic [4:0]          state
);

  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_MEM_ADDR = 5'd2,
    S_MEM_RD   = 5'd3,
    S_MEM_WB   = 5'd4,
    S_MEM_WR   = 5'd5,
    S_R_EXE    = 5'd6,
    S_R_WB     = 5'd7,
    S_BEQ      = 5'd8,
    S_BNE      = 5'd9,
    S_JUMP     = 5'd10,
    S_I_EXE    = 5'd11,
    S_I_WB     = 5'd12,
    S_JAL      = 5'd13,
    S_JR       = 5'd14,
    S_FAULT    = 5'd31
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

`ifdef CTRL_JAL_JR_EN
  localparam state_t JAL_DEST = S_JAL;
  localparam state_t JR_DEST  = S_JR;
`else
  localparam state_t JAL_DEST = S_FAULT;
  localparam state_t JR_DEST  = S_FAULT;
`endif

  localparam logic [WAIT_CNT_W-1:0] LIMIT   = WAIT_CNT_W'(WAIT_LIMIT);
  localparam logic [WAIT_CNT_W-1:0] WAIT_ONE = WAIT_CNT_W'(1);
  localparam logic [RETIRE_W-1:0]   RET_ONE  = RETIRE_W'(1);

  state_t                cur;
  logic [WAIT_CNT_W-1:0] wait_cnt;

  assign state = cur;

  // State transitions, memory-wait timeout and retire counting.
  // The wait counter is zero whenever a memory state is entered, because it is
  // cleared every time one of those states is left.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur          <= S_FETCH;
      wait_cnt     <= '0;
      retire_count <= '0;
    end else begin
      if (instr_done)
        retire_count <= retire_count + RET_ONE;
      case (cur)
        S_FETCH, S_MEM_RD, S_MEM_WR: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            if (cur == S_FETCH)
              cur <= S_DECODE;
            else if (cur == S_MEM_RD)
              cur <= S_MEM_WB;
            else
              cur <= S_FETCH;
          end else if (wait_cnt == LIMIT) begin
            wait_cnt <= '0;
            cur      <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_ONE;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_RTYPE:        cur <= (funct == FN_JR) ? JR_DEST : S_R_EXE;
            OP_LW, OP_SW:    cur <= S_MEM_ADDR;
            OP_BEQ:          cur <= S_BEQ;
            OP_BNE:          cur <= S_BNE;
            OP_J:            cur <= S_JUMP;
            OP_ADDI, OP_ANDI: cur <= S_I_EXE;
            OP_JAL:          cur <= JAL_DEST;
            default:         cur <= S_FAULT;
          endcase
        end
        S_MEM_ADDR: cur <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_R_EXE:    cur <= S_R_WB;
        S_I_EXE:    cur <= S_I_WB;
        S_MEM_WB, S_R_WB, S_BEQ, S_BNE, S_JUMP, S_I_WB, S_JAL, S_JR:
                    cur <= S_FETCH;
        S_FAULT:    cur <= S_FAULT;
        default:    cur <= S_FAULT;
      endcase
    end
  end

  // Moore strobe decode from the state register, with the mem_ready qualifiers.
  always_comb begin
    alusrc_a     = 1'b0;
    alusrc_b     = 2'b00;
    alu_op       = 2'b00;
    pc_src       = 2'b00;
    reg_dst      = 2'b00;
    mem_to_reg   = 2'b00;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    iord         = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_write_beq = 1'b0;
    pc_write_bne = 1'b0;
    instr_done   = 1'b0;
    fault        = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_read = 1'b1;
        alusrc_b = 2'b01;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE: alusrc_b = 2'b11;
      S_MEM_ADDR: begin
        alusrc_a = 1'b1;
        alusrc_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_R_EXE: begin
        alusrc_a = 1'b1;
        alu_op   = 2'b10;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 2'b01;
        instr_done = 1'b1;
      end
      S_BEQ, S_BNE: begin
        alusrc_a     = 1'b1;
        alu_op       = 2'b01;
        pc_src       = 2'b01;
        instr_done   = 1'b1;
        pc_write_beq = (cur == S_BEQ);
        pc_write_bne = (cur == S_BNE);
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        instr_done = 1'b1;
      end
      S_I_EXE: begin
        alusrc_a = 1'b1;
        alusrc_b = 2'b10;
        alu_op   = (opcode == OP_ANDI) ? 2'b11 : 2'b00;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        instr_done = 1'b1;
      end
      S_JR: begin
        pc_write   = 1'b1;
        pc_src     = 2'b11;
        instr_done = 1'b1;
      end
      S_FAULT: fault = 1'b1;
      default: fault = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed instruction sequences with memory stalls. The bench
// expands each instruction into its expected state path, and a per-cycle compare
// process checks every strobe, the state and the retire count against that path.
module tb_multicycle_ctrl;
  localparam int LIMIT = 15;
`ifdef CTRL_JAL_JR_EN
  localparam int JAL_ST = 13;
  localparam int JR_ST  = 14;
`else
  localparam int JAL_ST = 31;
  localparam int JR_ST  = 31;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        mem_ready = 1'b0;
  logic        alusrc_a, mem_read, mem_write, reg_write, iord, ir_write, pc_write;
  logic        pc_write_beq, pc_write_bne, instr_done, fault;
  logic [1:0]  alusrc_b, alu_op, pc_src, reg_dst, mem_to_reg;
  logic [31:0] retire_count;
  logic [4:0]  state;

  multicycle_ctrl #(.WAIT_CNT_W(4), .WAIT_LIMIT(LIMIT), .RETIRE_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .alu_op(alu_op), .pc_src(pc_src),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
    .pc_write_beq(pc_write_beq), .pc_write_bne(pc_write_bne), .instr_done(instr_done),
    .fault(fault), .retire_count(retire_count), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       alusrc_a;
    logic [1:0] alusrc_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_beq;
    logic       pc_write_bne;
    logic       instr_done;
    logic       fault;
  } ctl_t;

  ctl_t dut_ctl;
  always_comb begin
    dut_ctl              = '0;
    dut_ctl.alusrc_a     = alusrc_a;
    dut_ctl.alusrc_b     = alusrc_b;
    dut_ctl.alu_op       = alu_op;
    dut_ctl.pc_src       = pc_src;
    dut_ctl.reg_dst      = reg_dst;
    dut_ctl.mem_to_reg   = mem_to_reg;
    dut_ctl.mem_read     = mem_read;
    dut_ctl.mem_write    = mem_write;
    dut_ctl.reg_write    = reg_write;
    dut_ctl.iord         = iord;
    dut_ctl.ir_write     = ir_write;
    dut_ctl.pc_write     = pc_write;
    dut_ctl.pc_write_beq = pc_write_beq;
    dut_ctl.pc_write_bne = pc_write_bne;
    dut_ctl.instr_done   = instr_done;
    dut_ctl.fault        = fault;
  end

  int          tests = 0;
  int          fails = 0;
  int          exp_state = 0;
  logic [31:0] exp_retire = 32'd0;
  logic        chk_en = 1'b0;
  int          p_st[$];
  logic        p_rdy[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Strobes each state must show.
  function automatic ctl_t exp_ctl(input int st, input logic [5:0] op, input logic rdy);
    ctl_t c = '0;
    case (st)
      0:  begin c.mem_read = 1; c.alusrc_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      1:  c.alusrc_b = 2'b11;
      2:  begin c.alusrc_a = 1; c.alusrc_b = 2'b10; end
      3:  begin c.mem_read = 1; c.iord = 1; end
      4:  begin c.reg_write = 1; c.mem_to_reg = 2'b01; c.instr_done = 1; end
      5:  begin c.mem_write = 1; c.iord = 1; c.instr_done = rdy; end
      6:  begin c.alusrc_a = 1; c.alu_op = 2'b10; end
      7:  begin c.reg_write = 1; c.reg_dst = 2'b01; c.instr_done = 1; end
      8:  begin c.alusrc_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.instr_done = 1; c.pc_write_beq = 1; end
      9:  begin c.alusrc_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.instr_done = 1; c.pc_write_bne = 1; end
      10: begin c.pc_write = 1; c.pc_src = 2'b10; c.instr_done = 1; end
      11: begin c.alusrc_a = 1; c.alusrc_b = 2'b10; c.alu_op = (op == 6'h0c) ? 2'b11 : 2'b00; end
      12: begin c.reg_write = 1; c.instr_done = 1; end
      13: begin c.reg_write = 1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10; c.pc_write = 1; c.pc_src = 2'b10; c.instr_done = 1; end
      14: begin c.pc_write = 1; c.pc_src = 2'b11; c.instr_done = 1; end
      31: c.fault = 1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Per-cycle comparison against the expected path.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("state", 64'(state), 64'(exp_state));
      check("strobes", 64'(dut_ctl), 64'(exp_ctl(exp_state, opcode, mem_ready)));
      check("retire", 64'(retire_count), 64'(exp_retire));
    end
  end

  task automatic add(input int st);
    p_st.push_back(st);
    p_rdy.push_back(1'($urandom_range(0, 1)));
  endtask

  // A memory state with w not-ready cycles: ready arrives after w stalls, or
  // after LIMIT+1 stalls the controller is expected in FAULT.
  task automatic add_mem(input int st, input int w);
    if (w > LIMIT) begin
      for (int i = 0; i <= LIMIT; i++) begin p_st.push_back(st); p_rdy.push_back(1'b0); end
      add(31);
    end else begin
      for (int i = 0; i < w; i++) begin p_st.push_back(st); p_rdy.push_back(1'b0); end
      p_st.push_back(st);
      p_rdy.push_back(1'b1);
    end
  endtask

  task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
    p_st.delete();
    p_rdy.delete();
    add_mem(0, fw);
    if (p_st[$] != 31) begin
      add(1);
      case (op)
        6'h00: if (fn == 6'h08) add(JR_ST); else begin add(6); add(7); end
        6'h23: begin add(2); add_mem(3, mw); if (p_st[$] != 31) add(4); end
        6'h2b: begin add(2); add_mem(5, mw); end
        6'h04: add(8);
        6'h05: add(9);
        6'h02: add(10);
        6'h08, 6'h0c: begin add(11); add(12); end
        6'h03: add(JAL_ST);
        default: add(31);
      endcase
    end
    if (p_st[$] == 31) repeat (3) add(31);
  endtask

  task automatic step(input int st, input logic rdy);
    mem_ready = rdy;
    exp_state = st;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
    build(op, fn, fw, mw);
    opcode = op;
    funct = fn;
    foreach (p_st[i]) step(p_st[i], p_rdy[i]);
    if (p_st[$] != 31) exp_retire++;
    chk_en = 1'b0;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    reset = 1'b1;
    #2;
    check("rst_state", 64'(state), 64'd0);
    check("rst_retire", 64'(retire_count), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_mem_read", 64'(mem_read), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_retire = 32'd0;
  endtask

  initial begin
    #1;
    do_reset();

    run_instr(6'h23, 6'h00, 0, 0);            // lw: 0,1,2,3,4
    check("lw_len", 64'(p_st.size()), 64'd5);
    check("lw_retire", 64'(retire_count), 64'd1);
    run_instr(6'h2b, 6'h00, 0, 3);            // sw, 4 cycles in MEM_WR
    check("sw_retire", 64'(retire_count), 64'd2);
    run_instr(6'h05, 6'h00, 0, 0);            // bne
    check("bne_retire", 64'(retire_count), 64'd3);
    run_instr(6'h04, 6'h00, 0, 0);            // beq
    run_instr(6'h00, 6'h20, 0, 0);            // add
    run_instr(6'h08, 6'h00, 0, 0);            // addi
    run_instr(6'h0c, 6'h00, 0, 0);            // andi
    run_instr(6'h02, 6'h00, 0, 0);            // j
    run_instr(6'h23, 6'h00, 2, 4);            // lw with stalls
    run_instr(6'h02, 6'h00, LIMIT, 0);        // ready on 16th FETCH cycle
    check("late_ready_retire", 64'(retire_count), 64'd10);
    check("late_ready_state", 64'(state), 64'd0);

`ifdef CTRL_JAL_JR_EN
    run_instr(6'h03, 6'h00, 0, 0);            // jal
    run_instr(6'h00, 6'h08, 0, 0);            // jr
    check("jal_jr_retire", 64'(retire_count), 64'd12);
`else
    run_instr(6'h03, 6'h00, 0, 0);
    check("jal_fault", 64'(fault), 64'd1);
    do_reset();
    run_instr(6'h00, 6'h08, 0, 0);
    check("jr_fault", 64'(fault), 64'd1);
`endif
    do_reset();

    run_instr(6'h02, 6'h00, LIMIT + 1, 0);    // FETCH timeout
    check("timeout_fault", 64'(fault), 64'd1);
    check("timeout_state", 64'(state), 64'd31);
    do_reset();

    run_instr(6'h3f, 6'h00, 0, 0);            // illegal opcode
    check("illegal_state", 64'(state), 64'd31);
    do_reset();

    run_instr(6'h23, 6'h00, 0, LIMIT + 1);    // MEM_RD timeout
    check("memrd_timeout", 64'(fault), 64'd1);
    do_reset();

    run_instr(6'h02, 6'h00, 0, 0);
    check("pre_abort_retire", 64'(retire_count), 64'd1);
    opcode = 6'h23;
    step(0, 1'b1);
    step(1, 1'b0);
    step(2, 1'b0);
    do_reset();                               // abort lw in MEM_RD

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
